mult_iter_param: RTL and testbench

//  Parametrised iterative WIDTHxWIDTH multiplier, successor to the fixed 32x32 iterative unit.

---
 rtl/mult_iter_pkg.sv | 29 ++
 rtl/mult_iter_fsm.sv | 87 ++++++++
 rtl/mult_iter_param.sv | 104 ++++++++++
 tb/tb_mult_iter_param.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/mult_iter_pkg.sv
// Shared state type and operand helpers for the parametrised iterative multiplier.
package mult_iter_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      FIX  = 2'd2
   } mult_state_t;

   localparam int MAX_WIDTH = 64;

   // Magnitude of a w-bit value held zero-extended; the most negative value maps to 2^(w-1).
   function automatic logic [MAX_WIDTH-1:0] abs_val(
      input logic [MAX_WIDTH-1:0] x,
      input int                   w,
      input logic                 is_signed
   );
      logic [MAX_WIDTH-1:0] mask;
      logic [MAX_WIDTH-1:0] r;
      logic                 sgn;
      mask = (w >= MAX_WIDTH) ? '1 : ((MAX_WIDTH'(1) << w) - MAX_WIDTH'(1));
      r    = x & mask;
      sgn  = |(r & (MAX_WIDTH'(1) << (w - 1)));
      if (is_signed && sgn)
         r = (~r + MAX_WIDTH'(1)) & mask;
      return r;
   endfunction

endpackage

// File: rtl/mult_iter_fsm.sv
// Sequencer for the iterative multiplier: walks the digit pairs and issues capture/accumulate/fix strobes.
module mult_iter_fsm
   import mult_iter_pkg::*;
#(
   parameter  int N_DIGITS = 2,
   localparam int IDX_W    = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   output logic             busy,
   output logic             done,
   output logic             capture,
   output logic             accum,
   output logic             fix,
   output logic [IDX_W-1:0] ia,
   output logic [IDX_W-1:0] ib
);

   localparam logic [IDX_W-1:0] LAST = IDX_W'(N_DIGITS - 1);

   mult_state_t      state_q, state_d;
   logic [IDX_W-1:0] ia_q, ia_d;
   logic [IDX_W-1:0] ib_q, ib_d;
   logic             done_q, done_d;

   // The digit counter is kept as an (ia, ib) pair so ia is the fast-moving multiplicand digit.
   always_comb begin
      state_d = state_q;
      ia_d    = ia_q;
      ib_d    = ib_q;
      done_d  = 1'b0;
      capture = 1'b0;
      accum   = 1'b0;
      fix     = 1'b0;
      case (state_q)
         IDLE: begin
            if (start) begin
               capture = 1'b1;
               ia_d    = '0;
               ib_d    = '0;
               state_d = CALC;
            end
         end
         CALC: begin
            accum = 1'b1;
            if (ia_q == LAST) begin
               ia_d = '0;
               if (ib_q == LAST) begin
                  ib_d    = '0;
                  state_d = FIX;
               end else begin
                  ib_d = ib_q + IDX_W'(1);
               end
            end else begin
               ia_d = ia_q + IDX_W'(1);
            end
         end
         FIX: begin
            fix     = 1'b1;
            done_d  = 1'b1;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
         ia_q    <= '0;
         ib_q    <= '0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         ia_q    <= ia_d;
         ib_q    <= ib_d;
         done_q  <= done_d;
      end
   end

   assign busy = (state_q == CALC) || (state_q == FIX);
   assign done = done_q;
   assign ia   = ia_q;
   assign ib   = ib_q;

endmodule

// File: rtl/mult_iter_param.sv
// Parametrised iterative WIDTHxWIDTH multiplier: one CHUNKxCHUNK partial product per cycle,
// operands multiplied as magnitudes with the sign applied once at the end.
module mult_iter_param
   import mult_iter_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter int CHUNK = 16
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               start,
   input  logic               signed_mode,
   input  logic [WIDTH-1:0]   a,
   input  logic [WIDTH-1:0]   b,
   output logic               busy,
   output logic               done,
   output logic [2*WIDTH-1:0] product
);

   localparam int N     = WIDTH / CHUNK;
   localparam int IDX_W = (N > 1) ? $clog2(N) : 1;
   localparam int PW    = 2 * WIDTH;

   generate
      if (WIDTH % CHUNK != 0) begin : g_bad_chunk
         $error("mult_iter_param: WIDTH must be a multiple of CHUNK");
      end
      if (WIDTH > MAX_WIDTH) begin : g_bad_width
         $error("mult_iter_param: WIDTH exceeds MAX_WIDTH");
      end
   endgenerate

   logic             capture, accum, fix;
   logic [IDX_W-1:0] ia_sel, ib_sel;

   mult_iter_fsm #(
      .N_DIGITS (N)
   ) u_fsm (
      .clk     (clk),
      .reset   (reset),
      .start   (start),
      .busy    (busy),
      .done    (done),
      .capture (capture),
      .accum   (accum),
      .fix     (fix),
      .ia      (ia_sel),
      .ib      (ib_sel)
   );

   logic [WIDTH-1:0]   a_mag_q, a_mag_d;
   logic [WIDTH-1:0]   b_mag_q, b_mag_d;
   logic               neg_q, neg_d;
   logic [PW-1:0]      acc_q, acc_d;
   logic [PW-1:0]      product_q, product_d;
   logic [CHUNK-1:0]   a_dig, b_dig;
   logic [2*CHUNK-1:0] pp;
   logic [PW-1:0]      pp_shift;

   always_comb begin
      a_dig    = CHUNK'(a_mag_q >> (int'(ia_sel) * CHUNK));
      b_dig    = CHUNK'(b_mag_q >> (int'(ib_sel) * CHUNK));
      pp       = (2*CHUNK)'(a_dig) * (2*CHUNK)'(b_dig);
      pp_shift = PW'(pp) << ((int'(ia_sel) + int'(ib_sel)) * CHUNK);
   end

   // Operands are only captured from IDLE, so later changes on a/b/signed_mode cannot disturb a running op.
   always_comb begin
      a_mag_d   = a_mag_q;
      b_mag_d   = b_mag_q;
      neg_d     = neg_q;
      acc_d     = acc_q;
      product_d = product_q;
      if (capture) begin
         a_mag_d = WIDTH'(abs_val(MAX_WIDTH'(a), WIDTH, signed_mode));
         b_mag_d = WIDTH'(abs_val(MAX_WIDTH'(b), WIDTH, signed_mode));
         neg_d   = signed_mode & (a[WIDTH-1] ^ b[WIDTH-1]);
         acc_d   = '0;
      end else if (accum) begin
         acc_d = acc_q + pp_shift;
      end
      if (fix)
         product_d = neg_q ? -acc_q : acc_q;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         a_mag_q   <= '0;
         b_mag_q   <= '0;
         neg_q     <= 1'b0;
         acc_q     <= '0;
         product_q <= '0;
      end else begin
         a_mag_q   <= a_mag_d;
         b_mag_q   <= b_mag_d;
         neg_q     <= neg_d;
         acc_q     <= acc_d;
         product_q <= product_d;
      end
   end

   assign product = product_q;

endmodule

// File: tb/tb_mult_iter_param.sv
// Self-checking bench for mult_iter_param: three CHUNK variants (16, 8, 32) of a 32-bit multiplier
// driven with directed corner cases and random back-to-back operations against a plain arithmetic model.
module tb_mult_iter_param;

   logic             clk = 1'b0;
   logic             reset;
   logic [2:0]       startV;
   logic [2:0]       smV;
   logic [2:0][31:0] aV;
   logic [2:0][31:0] bV;
   logic [2:0]       busyV;
   logic [2:0]       doneV;
   logic [2:0][63:0] prodV;
   logic [63:0]      lastProd [3];

   int checks   = 0;
   int failures = 0;

   // Free-running 10-time-unit clock shared by all three instances.
   always #5 clk = ~clk;

   mult_iter_param #(.WIDTH(32), .CHUNK(16)) u_mul16 (
      .clk(clk), .reset(reset), .start(startV[0]), .signed_mode(smV[0]),
      .a(aV[0]), .b(bV[0]), .busy(busyV[0]), .done(doneV[0]), .product(prodV[0])
   );

   mult_iter_param #(.WIDTH(32), .CHUNK(8)) u_mul8 (
      .clk(clk), .reset(reset), .start(startV[1]), .signed_mode(smV[1]),
      .a(aV[1]), .b(bV[1]), .busy(busyV[1]), .done(doneV[1]), .product(prodV[1])
   );

   mult_iter_param #(.WIDTH(32), .CHUNK(32)) u_mul32 (
      .clk(clk), .reset(reset), .start(startV[2]), .signed_mode(smV[2]),
      .a(aV[2]), .b(bV[2]), .busy(busyV[2]), .done(doneV[2]), .product(prodV[2])
   );

   // Single comparison point: counts every check and reports any mismatch.
   task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("[TB] FAIL %s: got 0x%h, expected 0x%h", tag, obs, exp);
      end
   endtask

   // Reference product straight from integer arithmetic on the full operands.
   function automatic logic [63:0] refMul(input logic [31:0] x, input logic [31:0] y, input logic sm);
      longint          sx, sy;
      longint unsigned ux, uy;
      if (sm) begin
         sx = longint'($signed(x));
         sy = longint'($signed(y));
         return 64'(sx * sy);
      end
      ux = {32'd0, x};
      uy = {32'd0, y};
      return ux * uy;
   endfunction

   // Latency (start edge to done cycle) is digits squared plus one fix cycle.
   function automatic int expLatency(input int inst);
      int chunk;
      int n;
      chunk = (inst == 0) ? 16 : (inst == 1) ? 8 : 32;
      n     = 32 / chunk;
      return n * n + 1;
   endfunction

   // Launches one op, scrambles the inputs after capture, and checks timing, busy and result.
   // Returns in the done cycle so a following call starts back-to-back.
   task automatic applyStimulus(input int inst, input logic [31:0] av, input logic [31:0] bv,
                                input logic sm, input bit pokeBusy);
      logic [63:0] expProd;
      int          cyc;
      int          busyCycles;
      int          lat;
      expProd = refMul(av, bv, sm);
      lat     = expLatency(inst);
      @(negedge clk);
      startV[inst] = 1'b1;
      aV[inst]     = av;
      bV[inst]     = bv;
      smV[inst]    = sm;
      @(posedge clk);
      #1;
      startV[inst] = 1'b0;
      aV[inst]     = $urandom;
      bV[inst]     = $urandom;
      smV[inst]    = 1'($urandom);
      checkOutput($sformatf("u%0d_done_after_start", inst), 64'(doneV[inst]), 64'd0);
      checkOutput($sformatf("u%0d_product_held", inst), prodV[inst], lastProd[inst]);
      cyc        = 0;
      busyCycles = 0;
      while (!doneV[inst] && cyc < lat + 20) begin
         if (busyV[inst]) busyCycles++;
         startV[inst] = pokeBusy && (cyc == 1);
         if (pokeBusy && cyc == 1) aV[inst] = 32'd5;
         @(posedge clk);
         #1;
         cyc++;
      end
      startV[inst] = 1'b0;
      checkOutput($sformatf("u%0d_latency", inst), 64'(cyc), 64'(lat));
      checkOutput($sformatf("u%0d_busy_cycles", inst), 64'(busyCycles), 64'(lat));
      checkOutput($sformatf("u%0d_busy_at_done", inst), 64'(busyV[inst]), 64'd0);
      checkOutput($sformatf("u%0d_product a=%h b=%h s=%0d", inst, av, bv, sm), prodV[inst], expProd);
      lastProd[inst] = expProd;
   endtask

   // Idles an instance and confirms no stray done pulse, busy stays low and the result holds.
   task automatic waitQuiet(input int inst, input int cycles);
      int doneSeen;
      doneSeen = 0;
      repeat (cycles) begin
         @(posedge clk);
         #1;
         if (doneV[inst]) doneSeen++;
      end
      checkOutput($sformatf("u%0d_no_stray_done", inst), 64'(doneSeen), 64'd0);
      checkOutput($sformatf("u%0d_idle_busy", inst), 64'(busyV[inst]), 64'd0);
      checkOutput($sformatf("u%0d_idle_product", inst), prodV[inst], lastProd[inst]);
   endtask

   // Stops a hung run with a failure line instead of spinning forever.
   initial begin
      #2000000;
      $display("[TB] FAIL watchdog: simulation time exceeded, got timeout, expected finish");
      $fatal(1, "[TB] watchdog expired");
   end

   // Directed cases first, then a randomised regression across all three variants.
   initial begin
      logic [31:0] corners [5];
      logic [31:0] av, bv;
      int          inst;
      corners = '{32'h0000_0000, 32'h0000_0001, 32'h8000_0000, 32'hFFFF_FFFF, 32'h7FFF_FFFF};

      reset  = 1'b1;
      startV = '0;
      smV    = '0;
      aV     = '0;
      bV     = '0;
      for (int i = 0; i < 3; i++) lastProd[i] = 64'd0;
      repeat (3) @(posedge clk);
      #1;
      reset = 1'b0;
      @(posedge clk);
      #1;
      for (int i = 0; i < 3; i++) begin
         checkOutput($sformatf("u%0d_reset_busy", i), 64'(busyV[i]), 64'd0);
         checkOutput($sformatf("u%0d_reset_done", i), 64'(doneV[i]), 64'd0);
         checkOutput($sformatf("u%0d_reset_product", i), prodV[i], 64'd0);
      end

      applyStimulus(0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b0);
      checkOutput("u0_all_ones_const", prodV[0], 64'hFFFF_FFFE_0000_0001);
      applyStimulus(0, 32'hFFFF_FFFF, 32'h0000_0002, 1'b1, 1'b0);
      checkOutput("u0_minus1_x2_const", prodV[0], 64'hFFFF_FFFF_FFFF_FFFE);
      applyStimulus(0, 32'hFFFF_FFFF, 32'h0000_0002, 1'b0, 1'b0);
      applyStimulus(0, 32'h8000_0000, 32'h8000_0000, 1'b1, 1'b0);
      checkOutput("u0_minneg_sq_const", prodV[0], 64'h4000_0000_0000_0000);
      applyStimulus(0, 32'h8000_0000, 32'h0000_0001, 1'b1, 1'b0);

      applyStimulus(0, 32'd7, 32'd9, 1'b0, 1'b1);
      waitQuiet(0, 10);

      @(negedge clk);
      startV[0] = 1'b1;
      aV[0]     = 32'h0000_1234;
      bV[0]     = 32'h0000_5678;
      smV[0]    = 1'b0;
      @(posedge clk);
      #1;
      startV[0] = 1'b0;
      @(posedge clk);
      #1;
      checkOutput("u0_busy_before_reset", 64'(busyV[0]), 64'd1);
      reset = 1'b1;
      @(posedge clk);
      #1;
      checkOutput("u0_abort_busy", 64'(busyV[0]), 64'd0);
      checkOutput("u0_abort_done", 64'(doneV[0]), 64'd0);
      checkOutput("u0_abort_product", prodV[0], 64'd0);
      reset = 1'b0;
      for (int i = 0; i < 3; i++) lastProd[i] = 64'd0;
      waitQuiet(0, 8);

      applyStimulus(1, 32'h1234_5678, 32'h9ABC_DEF0, 1'b0, 1'b0);
      checkOutput("u1_chunk8_const", prodV[1], 64'h0B00_EA4E_242D_2080);
      applyStimulus(1, 32'h8000_0000, 32'h7FFF_FFFF, 1'b1, 1'b0);
      applyStimulus(2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 1'b0);
      applyStimulus(2, 32'hDEAD_BEEF, 32'h0000_0003, 1'b0, 1'b0);

      for (int r = 0; r < 60; r++) begin
         inst = r % 3;
         av   = ($urandom_range(0, 3) == 0) ? corners[$urandom_range(0, 4)] : 32'($urandom);
         bv   = ($urandom_range(0, 3) == 0) ? corners[$urandom_range(0, 4)] : 32'($urandom);
         applyStimulus(inst, av, bv, 1'($urandom), 1'b0);
         if ($urandom_range(0, 1) == 1) repeat ($urandom_range(1, 3)) @(posedge clk);
      end

      waitQuiet(1, 4);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
